// File: rtl/serial_pattern_sequencer_if.sv
// Bundle of the board-side handshake and detector-side serial link for serial_pattern_sequencer.
// The sequencer itself uses the slave modport; the surrounding logic uses master.
interface serial_pattern_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int IDX_W = 4
) ();
    logic             start;
    logic [WIDTH-1:0] word;
    logic             step_en;
    logic             det_z;
    logic             det_w;
    logic             det_en;
    logic             det_resetn;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_count;
    logic [IDX_W-1:0] first_hit_idx;
    logic             hit_seen;

    modport slave (
        input  start, word, step_en, det_z,
        output det_w, det_en, det_resetn, busy, done, hit_count, first_hit_idx, hit_seen
    );

    modport master (
        output start, word, step_en, det_z,
        input  det_w, det_en, det_resetn, busy, done, hit_count, first_hit_idx, hit_seen
    );
endinterface

// File: rtl/serial_pattern_sequencer.sv
// Feeds a latched pattern MSB-first into the serial sequence detector and tallies its hits.
// Define SEQ_PACE_EN to advance the shift only on step_en; otherwise one bit per clk.
module serial_pattern_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int IDX_W = 4
) (
    input  logic clk,
    input  logic resetn,
    serial_pattern_sequencer_if.slave bus
);
    // state   | meaning
    // S_IDLE  | waiting for start
    // S_CLEAR | detector held in reset for one cycle
    // S_SHIFT | presenting pattern bit k on det_w
    // S_DRAIN | sampling z for the last bit
    // S_DONE  | one-cycle done pulse, start accepted as in idle
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             smp_q, smp_d;
    logic [IDX_W-1:0] smp_idx_q, smp_idx_d;
    logic             det_w_q, det_w_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [IDX_W-1:0] first_hit_idx_q, first_hit_idx_d;
    logic             hit_seen_q, hit_seen_d;
    logic             step;

`ifdef SEQ_PACE_EN
    assign step       = (state_q == S_SHIFT) && bus.step_en;
    assign bus.det_en = step;
`else
    logic det_en_q, det_en_d;
    logic step_en_unused;

    assign step_en_unused = bus.step_en;
    assign step           = (state_q == S_SHIFT);
    assign bus.det_en     = det_en_q;
`endif

    always_comb begin
        state_d         = state_q;
        pat_d           = pat_q;
        k_d             = k_q;
        det_w_d         = det_w_q;
        hit_count_d     = hit_count_q;
        first_hit_idx_d = first_hit_idx_q;
        hit_seen_d      = hit_seen_q;
        smp_d           = step;
        smp_idx_d       = step ? k_q : smp_idx_q;

        // z reflects the bit stepped in the previous cycle
        if (smp_q && bus.det_z) begin
            if (hit_count_q != {CNT_W{1'b1}}) begin
                hit_count_d = hit_count_q + 1'b1;
            end
            if (!hit_seen_q) begin
                hit_seen_d      = 1'b1;
                first_hit_idx_d = smp_idx_q;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    pat_d           = bus.word;
                    hit_count_d     = '0;
                    hit_seen_d      = 1'b0;
                    first_hit_idx_d = '0;
                    state_d         = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_d = S_SHIFT;
                k_d     = '0;
                det_w_d = pat_q[WIDTH-1];
            end
            S_SHIFT: begin
                if (step) begin
                    if (k_q == K_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        k_d     = k_q + 1'b1;
                        pat_d   = pat_q << 1;
                        det_w_d = pat_q[WIDTH-2];
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CLEAR) || (state_d == S_SHIFT) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
`ifndef SEQ_PACE_EN
        det_en_d = (state_d == S_SHIFT);
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            pat_q           <= '0;
            k_q             <= '0;
            smp_q           <= 1'b0;
            smp_idx_q       <= '0;
            det_w_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            hit_count_q     <= '0;
            first_hit_idx_q <= '0;
            hit_seen_q      <= 1'b0;
`ifndef SEQ_PACE_EN
            det_en_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            pat_q           <= pat_d;
            k_q             <= k_d;
            smp_q           <= smp_d;
            smp_idx_q       <= smp_idx_d;
            det_w_q         <= det_w_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            hit_count_q     <= hit_count_d;
            first_hit_idx_q <= first_hit_idx_d;
            hit_seen_q      <= hit_seen_d;
`ifndef SEQ_PACE_EN
            det_en_q        <= det_en_d;
`endif
        end
    end

    // board reset also clears the detector
    assign bus.det_resetn    = resetn && (state_q != S_CLEAR);
    assign bus.det_w         = det_w_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.hit_count     = hit_count_q;
    assign bus.first_hit_idx = first_hit_idx_q;
    assign bus.hit_seen      = hit_seen_q;
endmodule

// File: doc/serial_pattern_sequencer.md
# serial_pattern_sequencer

Controller that drives the one-hot serial sequence detector from a parallel word. It latches a WIDTH-bit pattern on a start request, clears the detector, and presents the pattern one bit per step on the detector's serial input `w`. It counts the cycles where the detector output `z` is high, then reports the results with a `busy`/`done` handshake. It sits between the board-level switch/key logic and the detector instance, and owns the detector's reset.

## Interface
- `WIDTH`, 16: pattern length in bits, minimum 2.
- `CNT_W`, 5: hit-counter width.
- `IDX_W`, 4: width of the bit index. Must satisfy 2^IDX_W ≥ WIDTH.
- `clk` in 1: clock.
- `resetn` in 1: reset. Synchronous, active-low.
- `start` in 1: request a run. Sampled only in IDLE or DONE.
- `word` in WIDTH: pattern. Latched when `start` is accepted.
- `step_en` in 1: pacing tick. Used only when SEQ_PACE_EN is defined.
- `det_z` in 1: detector output, Moore-registered.
- `det_w` out 1: serial bit to the detector.
- `det_en` out 1: detector state-update enable.
- `det_resetn` out 1: detector synchronous reset, active-low.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at the end of a run.
- `hit_count` out CNT_W: number of `z` hits in the last run. Saturating.
- `first_hit_idx` out IDX_W: index of the bit that produced the first hit.
- `hit_seen` out 1: at least one hit occurred in the last run.

## Operation
- FSM states: IDLE → CLEAR → SHIFT → DRAIN → DONE → IDLE.
- In DONE, `start` behaves exactly as in IDLE.
- **IDLE/DONE:** when `start`=1, latch `word`, clear `hit_count`, `hit_seen` and `first_hit_idx`, and go to CLEAR. Otherwise:
  - IDLE holds;
  - DONE returns to IDLE.
- **CLEAR:** one cycle. `det_resetn`=0 and `det_en`=0. Go to SHIFT with bit index k=0.
- **SHIFT:** `det_w` = latched bit WIDTH-1-k (MSB first).
  - On each step, `det_en`=1 for that cycle, then k increments.
  - After the step with k=WIDTH-1, go to DRAIN.
- **Hit sampling:** `det_z` is sampled in the cycle after each step. The sample for bit k is taken in the next SHIFT cycle or in DRAIN.
  - When a sample is 1, `hit_count` increments. It saturates at 2^CNT_W-1 and never wraps.
  - On the first hit of a run, `hit_seen`=1 and `first_hit_idx`=k.
- **DRAIN:** samples `z` for the last bit and waits for no further step. `det_en`=0. Go to DONE.
- **DONE:** `done`=1 and `busy`=0 for exactly this cycle.
- `busy`=1 in CLEAR, SHIFT and DRAIN.
- Results hold until the next accepted `start`.
- `start` while `busy`=1 is ignored and is not queued.
- `det_resetn` = `resetn` AND NOT(state==CLEAR), so a board reset also clears the detector.
- `det_w` holds its last value outside SHIFT; it is 0 after reset.

## Timing
- Reset values:
  - state IDLE;
  - `det_w`=0, `det_en`=0, `det_resetn`=0;
  - `busy`=0, `done`=0;
  - `hit_count`=0, `first_hit_idx`=0, `hit_seen`=0.
- Reset mid-run: the FSM returns to IDLE on the next edge. No `done` pulse is produced, and all results clear.
- Unpaced run (`start` accepted at edge E0):
  - CLEAR in cycle 1;
  - bit k presented in cycle 2+k, with `det_en`=1 in every cycle;
  - DRAIN in cycle WIDTH+2;
  - `done` in cycle WIDTH+3.
  - Total: start to `done` is WIDTH+3 cycles.
- Paced run: a step occurs only in SHIFT cycles with `step_en`=1. Sampling follows each step by exactly one cycle.
  - `step_en` in CLEAR, DRAIN or DONE has no effect.
- All outputs are registered except `det_resetn`, which is the combinational AND given in Operation.

## Configuration
- `SEQ_PACE_EN` defined: SHIFT advances only on `step_en`, and `det_en`=`step_en` in SHIFT.
- `SEQ_PACE_EN` undefined: `step_en` is ignored and one bit is shifted per clk.

## Test plan
Bench detector model: `z`=1 in the cycle after the last four `w` bits are all 0 or all 1, cleared by `det_resetn`=0.
- Unpaced, WIDTH=16, `word`=16'hF000 → `done` 19 cycles after `start`; `hit_count`=10, `first_hit_idx`=3, `hit_seen`=1.
- `word`=16'hAAAA → `hit_count`=0, `hit_seen`=0, `first_hit_idx`=0; `done` pulses exactly once.
- CNT_W=3, `word`=16'h0000 → 13 raw hits; `hit_count` saturates at 7 and `first_hit_idx`=3.
- `start` pulsed again in cycle 5 of a run with a different `word` → ignored; results match the first word. `start` held in the DONE cycle → a new run begins, with CLEAR in the next cycle.
- `resetn`=0 in cycle 8 of a run → next cycle: IDLE, `busy`=0, `det_resetn`=0, counters 0, no `done`.
- SEQ_PACE_EN defined, `step_en` high every 3rd cycle, `word`=16'hF000 → `det_en` pulses 16 times, `hit_count`=10, and `done` follows the cycle after DRAIN.
